// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and constants for the FIFO read-side stream controller.
package fifo_rd_stream_pkg;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_state_t;

   localparam int BUF_DEPTH   = 2;
   localparam int RD_LAT_COMB = 0;
   localparam int RD_LAT_REG  = 1;

   // Number of words held for a given occupancy state.
   function automatic logic [1:0] occ_count(input occ_state_t s);
      case (s)
         OCC_EMPTY: occ_count = 2'd0;
         OCC_ONE:   occ_count = 2'd1;
         OCC_TWO:   occ_count = 2'd2;
         default:   occ_count = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/fifo_rd_stream_skid_buf.sv
// Two-entry in-order skid buffer with its occupancy FSM, plus a checker for the
// buffer's structural invariants.
module stream_skid_buf
   import fifo_rd_stream_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [1:0]       o_occ,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_head_data
);
   occ_state_t       r_occ;
   logic             r_valid;
   logic [WIDTH-1:0] r_head;
   logic [WIDTH-1:0] r_tail;

   // Occupancy FSM; head always holds the oldest word so the output is stable.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_occ   <= OCC_EMPTY;
         r_valid <= 1'b0;
         r_head  <= '0;
         r_tail  <= '0;
      end else begin
         case (r_occ)
            OCC_EMPTY: begin
               if (i_push) begin
                  r_head  <= i_push_data;
                  r_occ   <= OCC_ONE;
                  r_valid <= 1'b1;
               end
            end
            OCC_ONE: begin
               if (i_push && i_pop) begin
                  r_head <= i_push_data;
               end else if (i_push) begin
                  r_tail <= i_push_data;
                  r_occ  <= OCC_TWO;
               end else if (i_pop) begin
                  r_occ   <= OCC_EMPTY;
                  r_valid <= 1'b0;
               end
            end
            OCC_TWO: begin
               if (i_pop) begin
                  r_head <= r_tail;
                  if (i_push) begin
                     r_tail <= i_push_data;
                  end else begin
                     r_occ <= OCC_ONE;
                  end
               end
            end
            default: begin
               r_occ   <= OCC_EMPTY;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_occ       = r_occ;
   assign o_valid     = r_valid;
   assign o_head_data = r_head;

   stream_skid_buf_chk u_chk (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (i_push),
      .i_pop   (i_pop),
      .i_occ   (o_occ),
      .i_valid (o_valid)
   );
endmodule

module stream_skid_buf_chk
   import fifo_rd_stream_pkg::*;
(
   input logic       i_clk,
   input logic       i_rst,
   input logic       i_push,
   input logic       i_pop,
   input logic [1:0] i_occ,
   input logic       i_valid
);
   // Buffer must never overflow, underflow, or disagree with its valid flag.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         a_no_overflow: assert (!(i_push && !i_pop && (i_occ == OCC_TWO)))
            else $error("stream_skid_buf: push into full buffer");
         a_no_underflow: assert (!(i_pop && (i_occ == OCC_EMPTY)))
            else $error("stream_skid_buf: pop from empty buffer");
         a_valid_match: assert (i_valid == (i_occ != OCC_EMPTY))
            else $error("stream_skid_buf: valid disagrees with occupancy");
      end
   end
endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a FIFO read port into a framed valid/ready stream, for both
// combinational (RD_LATENCY=0) and registered (RD_LATENCY=1) FIFO reads.
module fifo_rd_stream
   import fifo_rd_stream_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int RD_LATENCY = 1,
   parameter int FRAME_LEN  = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 enable,
   input  logic                 fifo_empty,
   output logic                 fifo_rd_en,
   input  logic [WIDTH-1:0]     fifo_rd_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [WIDTH-1:0]     m_data,
   output logic                 m_last,
   output logic [CNT_WIDTH-1:0] frame_count,
   output logic                 busy
);
   localparam int                BEAT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(FRAME_LEN - 1);
   localparam logic              LAT_REG   = (RD_LATENCY == RD_LAT_REG);

   if ((RD_LATENCY != RD_LAT_COMB) && (RD_LATENCY != RD_LAT_REG)) begin : g_bad_latency
      $fatal(1, "fifo_rd_stream: RD_LATENCY must be 0 or 1");
   end
   if (FRAME_LEN < 1) begin : g_bad_frame
      $fatal(1, "fifo_rd_stream: FRAME_LEN must be at least 1");
   end

   logic [1:0]           w_occ;
   logic                 w_valid;
   logic [WIDTH-1:0]     w_head;
   logic                 w_pop;
   logic                 w_push;
   logic                 w_rd_en;
   logic                 w_inflight;
   logic [1:0]           w_occ_cnt;
   logic [1:0]           w_occ_cnt_nxt;
   logic [2:0]           w_committed;
   logic [BEAT_W-1:0]    w_beat_nxt;

   logic                 r_inflight;
   logic                 r_last;
   logic                 r_busy;
   logic [BEAT_W-1:0]    r_beat;
   logic [CNT_WIDTH-1:0] r_frame_count;

   // Issue a read only if the word is guaranteed a buffer slot when it lands.
   always_comb begin
      w_pop       = w_valid && m_ready;
      w_inflight  = LAT_REG ? r_inflight : 1'b0;
      w_occ_cnt   = occ_count(occ_state_t'(w_occ));
      w_committed = {1'b0, w_occ_cnt} + {2'b00, w_inflight} - {2'b00, w_pop};
      w_rd_en     = !i_rst && enable && !fifo_empty && (w_committed < 3'(BUF_DEPTH));
      w_push      = LAT_REG ? w_inflight : w_rd_en;
      w_occ_cnt_nxt = w_occ_cnt + {1'b0, w_push} - {1'b0, w_pop};
      if (w_pop) begin
         w_beat_nxt = (r_beat == BEAT_LAST) ? '0 : (r_beat + BEAT_W'(1));
      end else begin
         w_beat_nxt = r_beat;
      end
   end

   // In-flight tracking, framing and registered status outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_inflight    <= 1'b0;
         r_beat        <= '0;
         r_frame_count <= '0;
         r_last        <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_inflight <= LAT_REG ? w_rd_en : 1'b0;
         r_beat     <= w_beat_nxt;
         if (w_pop && r_last) begin
            r_frame_count <= r_frame_count + CNT_WIDTH'(1);
         end
         r_last <= (w_occ_cnt_nxt != 2'd0) && (w_beat_nxt == BEAT_LAST);
         r_busy <= (w_occ_cnt_nxt != 2'd0) || (LAT_REG && w_rd_en);
      end
   end

   stream_skid_buf #(
      .WIDTH (WIDTH)
   ) u_buf (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_push      (w_push),
      .i_push_data (fifo_rd_data),
      .i_pop       (w_pop),
      .o_occ       (w_occ),
      .o_valid     (w_valid),
      .o_head_data (w_head)
   );

   assign fifo_rd_en  = w_rd_en;
   assign m_valid     = w_valid;
   assign m_data      = w_head;
   assign m_last      = r_last;
   assign frame_count = r_frame_count;
   assign busy        = r_busy;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: four instances (latency 0/1, frame lengths 4/5/1),
// each fed by a FIFO model and checked against an in-order word scoreboard.
module tb_fifo_rd_stream;
   logic             clk = 1'b0;
   logic             rst;
   logic [3:0]       en_v;
   logic [3:0]       ready_v;
   logic [3:0]       empty_v;
   logic [3:0]       rd_en_v;
   logic [3:0][7:0]  rd_data_v;
   logic [3:0]       m_valid_v;
   logic [3:0][7:0]  m_data_v;
   logic [3:0]       m_last_v;
   logic [3:0][15:0] fc_v;
   logic [3:0]       busy_v;

   logic [7:0]       mem [4][256];
   int               wp [4];
   int               rp [4] = '{0, 0, 0, 0};
   logic [3:0][7:0]  rd_q;

   int               n_cmp;
   int               n_bad;

   always #5 clk = ~clk;

   function automatic int lat(input int k);
      return ((k == 1) || (k == 3)) ? 0 : 1;
   endfunction

   function automatic int flen(input int k);
      return (k == 2) ? 5 : ((k == 3) ? 1 : 4);
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int LAT = ((g == 1) || (g == 3)) ? 0 : 1;
      localparam int FL  = (g == 2) ? 5 : ((g == 3) ? 1 : 4);
      fifo_rd_stream #(
         .WIDTH      (8),
         .RD_LATENCY (LAT),
         .FRAME_LEN  (FL),
         .CNT_WIDTH  (16)
      ) u_dut (
         .i_clk        (clk),
         .i_rst        (rst),
         .enable       (en_v[g]),
         .fifo_empty   (empty_v[g]),
         .fifo_rd_en   (rd_en_v[g]),
         .fifo_rd_data (rd_data_v[g]),
         .m_valid      (m_valid_v[g]),
         .m_ready      (ready_v[g]),
         .m_data       (m_data_v[g]),
         .m_last       (m_last_v[g]),
         .frame_count  (fc_v[g]),
         .busy         (busy_v[g])
      );
   end

   // FIFO model: flags and combinational/registered read data
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         empty_v[k]   = (rp[k] == wp[k]);
         rd_data_v[k] = (lat(k) == 0) ? mem[k][rp[k][7:0]] : rd_q[k];
      end
   end

   always @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (rd_en_v[k]) begin
            rd_q[k] <= mem[k][rp[k][7:0]];
            rp[k]   <= rp[k] + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_word(input int k, input logic [7:0] v);
      mem[k][wp[k][7:0]] = v;
      wp[k] = wp[k] + 1;
   endtask

   // Scoreboard: every word the FIFO gave up is delivered once, in order,
   // with framing derived from the number of transfers since reset.
   int         exp_idx [4];
   int         beats [4];
   bit         hold [4];
   logic [7:0] hold_data [4];
   logic       hold_last [4];
   bit         post_rst [4];
   bit         active = 1'b0;

   always @(negedge clk) begin
      #1;
      for (int k = 0; k < 4; k++) begin
         if (rst) begin
            active = 1'b1;
            chk($sformatf("rd_en_in_reset[%0d]", k), rd_en_v[k], 0);
            exp_idx[k]  = rp[k];
            beats[k]    = 0;
            hold[k]     = 1'b0;
            post_rst[k] = 1'b1;
         end else if (active) begin
            int pend;
            pend = rp[k] - exp_idx[k];
            if (post_rst[k]) begin
               chk($sformatf("rst_valid[%0d]", k), m_valid_v[k], 0);
               chk($sformatf("rst_last[%0d]", k), m_last_v[k], 0);
               chk($sformatf("rst_data[%0d]", k), m_data_v[k], 0);
               chk($sformatf("rst_fc[%0d]", k), fc_v[k], 0);
               chk($sformatf("rst_busy[%0d]", k), busy_v[k], 0);
               post_rst[k] = 1'b0;
            end
            if (hold[k]) begin
               chk($sformatf("hold_valid[%0d]", k), m_valid_v[k], 1);
               chk($sformatf("hold_data[%0d]", k), m_data_v[k], hold_data[k]);
               chk($sformatf("hold_last[%0d]", k), m_last_v[k], hold_last[k]);
            end
            chk($sformatf("rd_en_legal[%0d]", k),
                rd_en_v[k] && !(en_v[k] && !empty_v[k]), 0);
            chk($sformatf("busy[%0d]", k), busy_v[k], (pend != 0));
            chk($sformatf("pending_le_2[%0d]", k), (pend <= 2), 1);
            chk($sformatf("frame_count[%0d]", k), fc_v[k], (beats[k] / flen(k)) % 65536);
            if (m_valid_v[k]) begin
               chk($sformatf("data[%0d]", k), m_data_v[k], mem[k][exp_idx[k] % 256]);
               chk($sformatf("last[%0d]", k), m_last_v[k],
                   ((beats[k] % flen(k)) == (flen(k) - 1)));
               if (ready_v[k]) begin
                  exp_idx[k]++;
                  beats[k]++;
               end
            end
            hold[k]      = m_valid_v[k] && !ready_v[k];
            hold_data[k] = m_data_v[k];
            hold_last[k] = m_last_v[k];
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int xf;
      int lasts;
      int pushed;
      n_cmp   = 0;
      n_bad   = 0;
      rst     = 1'b1;
      en_v    = 4'b0000;
      ready_v = 4'b1111;
      for (int k = 0; k < 4; k++) wp[k] = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #2;
      chk("reset_rd_en", rd_en_v[0], 0);

      // Latency 1, frame 4: 0x10..0x17 back to back, valid two cycles after rd_en
      for (int i = 0; i < 8; i++) push_word(0, 8'h10 + 8'(i));
      @(negedge clk); en_v[0] = 1'b1;
      #2; chk("l1_rd_en_c0", rd_en_v[0], 1); chk("l1_valid_c0", m_valid_v[0], 0);
      @(negedge clk); #2; chk("l1_valid_c1", m_valid_v[0], 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); #2;
         chk("l1_valid", m_valid_v[0], 1);
         chk("l1_data", m_data_v[0], 8'h10 + 8'(i));
         chk("l1_last", m_last_v[0], (i == 3) || (i == 7));
      end
      @(negedge clk); #2;
      chk("l1_drained", m_valid_v[0], 0); chk("l1_fc", fc_v[0], 2); chk("l1_busy", busy_v[0], 0);

      // Latency 0, frame 4: same stream, valid one cycle after rd_en
      for (int i = 0; i < 8; i++) push_word(1, 8'h10 + 8'(i));
      @(negedge clk); en_v[1] = 1'b1;
      #2; chk("l0_rd_en_c0", rd_en_v[1], 1); chk("l0_valid_c0", m_valid_v[1], 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); #2;
         chk("l0_valid", m_valid_v[1], 1);
         chk("l0_data", m_data_v[1], 8'h10 + 8'(i));
         chk("l0_last", m_last_v[1], (i == 3) || (i == 7));
      end
      @(negedge clk); #2;
      chk("l0_drained", m_valid_v[1], 0); chk("l0_fc", fc_v[1], 2);

      // Backpressure: two reads fill the buffer, then reads stop
      @(negedge clk); en_v[0] = 1'b0; ready_v[0] = 1'b0;
      for (int i = 0; i < 8; i++) push_word(0, 8'h20 + 8'(i));
      @(negedge clk); en_v[0] = 1'b1;
      n = 0;
      #2; if (rd_en_v[0]) n++;
      for (int c = 1; c < 10; c++) begin
         @(negedge clk); #2; if (rd_en_v[0]) n++;
      end
      chk("bp_rd_pulses", n, 2);
      chk("bp_valid", m_valid_v[0], 1);
      chk("bp_head", m_data_v[0], 8'h20);
      @(negedge clk); ready_v[0] = 1'b1;
      xf = 0;
      #2; if (m_valid_v[0] && ready_v[0]) xf++;
      for (int c = 1; c < 12; c++) begin
         @(negedge clk); #2; if (m_valid_v[0] && ready_v[0]) xf++;
      end
      chk("bp_xfers", xf, 8); chk("bp_fc", fc_v[0], 4);

      // Enable dropped after one read: in-flight word still arrives
      @(negedge clk); en_v[0] = 1'b0;
      for (int i = 0; i < 6; i++) push_word(0, 8'h30 + 8'(i));
      @(negedge clk); en_v[0] = 1'b1;
      #2; chk("en_rd_c0", rd_en_v[0], 1);
      @(negedge clk); en_v[0] = 1'b0;
      #2; chk("en_rd_c1", rd_en_v[0], 0); chk("en_busy_c1", busy_v[0], 1);
      @(negedge clk); #2;
      chk("en_valid_c2", m_valid_v[0], 1); chk("en_data_c2", m_data_v[0], 8'h30);
      @(negedge clk); #2;
      chk("en_valid_c3", m_valid_v[0], 0); chk("en_busy_c3", busy_v[0], 0);
      chk("en_rd_c3", rd_en_v[0], 0); chk("en_nonempty_c3", empty_v[0], 0);
      @(negedge clk); en_v[0] = 1'b1;
      xf = 0;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         #2;
         if (m_valid_v[0] && ready_v[0]) begin
            xf++;
            chk("en_resume_last", m_last_v[0], (m_data_v[0] == 8'h33));
         end
      end
      chk("en_resume_xfers", xf, 5); chk("en_fc", fc_v[0], 5);

      // FRAME_LEN=1: every beat is last
      for (int i = 0; i < 3; i++) push_word(3, 8'h50 + 8'(i));
      @(negedge clk); en_v[3] = 1'b1;
      lasts = 0;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) @(negedge clk);
         #2;
         if (m_valid_v[3] && ready_v[3] && m_last_v[3]) lasts++;
      end
      chk("f1_lasts", lasts, 3); chk("f1_fc", fc_v[3], 3);

      // Random ready with FIFO underruns, latency 1, frame 5
      en_v[2] = 1'b1;
      xf = 0; lasts = 0; pushed = 0;
      for (int c = 0; (c < 3000) && (xf < 100); c++) begin
         @(negedge clk);
         ready_v[2] = ($urandom_range(0, 1) == 1);
         if ((pushed < 100) && ($urandom_range(0, 2) == 0)) begin
            push_word(2, 8'($urandom_range(0, 255)));
            pushed++;
         end
         #2;
         if (m_valid_v[2] && ready_v[2]) begin
            xf++;
            if (m_last_v[2]) lasts++;
         end
      end
      chk("rnd_xfers", xf, 100); chk("rnd_lasts", lasts, 20);
      @(negedge clk); ready_v[2] = 1'b1;
      #2; chk("rnd_fc", fc_v[2], 20);

      // Reset while buffered and with a read in flight
      @(negedge clk); en_v[0] = 1'b0; ready_v[0] = 1'b0;
      for (int i = 0; i < 8; i++) push_word(0, 8'h40 + 8'(i));
      @(negedge clk); en_v[0] = 1'b1;
      repeat (3) @(negedge clk);
      @(negedge clk); ready_v[0] = 1'b1;
      #2; chk("rs_rd_before", rd_en_v[0], 1);
      @(negedge clk); rst = 1'b1;
      #2; chk("rs_rd_in_reset", rd_en_v[0], 0);
      @(negedge clk); rst = 1'b0;
      #2;
      chk("rs_valid", m_valid_v[0], 0); chk("rs_fc", fc_v[0], 0); chk("rs_busy", busy_v[0], 0);
      xf = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk); #2;
         if (m_valid_v[0] && ready_v[0]) begin
            if (xf == 0) chk("rs_first_data", m_data_v[0], 8'h43);
            chk("rs_last", m_last_v[0], (m_data_v[0] == 8'h46));
            xf++;
         end
      end
      chk("rs_xfers", xf, 5); chk("rs_fc_after", fc_v[0], 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
